// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that lets NREQ requesters take turns writing bursts of
//   up to BURST beats into a single FIFO write port. Data passes through
//   combinationally from the granted requester to the FIFO. Every grant goes
//   back through IDLE, so a requester that stays valid always gives the others
//   a chance to win arbitration between its bursts.
//
// Parameters
//   DATASIZE  FIFO word width
//   NREQ      number of requesters
//   BURST     maximum beats per grant (1..255)
//
// Ports
//   wclk            write-domain clock, all state on the rising edge
//   wrst_n          asynchronous active-low reset
//   req_valid       per-requester data valid
//   req_data        per-requester data, requester i at [i*DATASIZE +: DATASIZE]
//   req_ready       per-requester beat accepted this cycle
//   wfull           FIFO full flag, synchronous to wclk
//   w_en            FIFO write enable
//   wdata           FIFO write data (zero while idle)
//   grant_id        currently granted requester
//   busy            high while a grant is active
//   beat_cnt_total  running count of beats written, wraps at 2^32
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATASIZE = 64,
  parameter int NREQ     = 4,
  parameter int BURST    = 8,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     w_en,
  output logic [DATASIZE-1:0]      wdata,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [31:0]              beat_cnt_total
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0]     BURST_LAST = 8'(BURST - 1);
  localparam logic [IDW-1:0] LAST_RST   = IDW'(NREQ - 1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [IDW-1:0]      last_gnt_q, last_gnt_d;
  logic [7:0]          burst_q, burst_d;
  logic [31:0]         total_q, total_d;

  logic [IDW-1:0]      rr_sel;
  logic                rr_found;
  logic [IDW-1:0]      rr_cand;
  int                  rr_off;
  logic                sel_valid;
  logic [DATASIZE-1:0] sel_data;

  // Round-robin search: first valid requester starting one past the last
  // grant, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    rr_off   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_off = int'(last_gnt_q) + k;
      if (rr_off >= NREQ) begin
        rr_off = rr_off - NREQ;
      end
      rr_cand = IDW'(rr_off);
      if (!rr_found && req_valid[rr_cand]) begin
        rr_sel   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Granted requester's valid and data.
  assign sel_valid = req_valid[grant_id_q];

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_data = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  // Next-state and write-enable logic.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_gnt_d = last_gnt_q;
    burst_d    = burst_q;
    total_d    = total_q;
    w_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d    = GRANT;
          grant_id_d = rr_sel;
          burst_d    = '0;
        end
      end
      GRANT: begin
        // A dropped valid releases the grant even while the FIFO is full.
        if (!sel_valid) begin
          state_d    = IDLE;
          last_gnt_d = grant_id_q;
        end else if (!wfull) begin
          w_en    = 1'b1;
          burst_d = burst_q + 8'd1;
          total_d = total_q + 32'd1;
          if (burst_q == BURST_LAST) begin
            state_d    = IDLE;
            last_gnt_d = grant_id_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_gnt_q <= LAST_RST;
      burst_q    <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_gnt_q <= last_gnt_d;
      burst_q    <= burst_d;
      total_q    <= total_d;
    end
  end

  // Only the granted requester sees its beat accepted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_en && (grant_id_q == IDW'(i));
    end
  end

  assign busy           = (state_q == GRANT);
  assign wdata          = busy ? sel_data : '0;
  assign grant_id       = grant_id_q;
  assign beat_cnt_total = total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. A driver feeds each requester an
//   ordered stream of tagged words and pushes every new word into that
//   requester's expected queue. A monitor on the falling edge pops and compares
//   whenever the DUT writes, and separately predicts grant/release behaviour
//   from the round-robin rules. A 128-deep FIFO model with a slower read clock
//   supplies wfull.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int DATASIZE = 64;
  localparam int NREQ     = 4;
  localparam int BURST    = 8;
  localparam int IDW      = 2;
  localparam int DEPTH    = 128;

  logic                     wclk, rclk, wrst_n;
  logic [NREQ-1:0]          req_valid, req_ready;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic                     wfull, w_en, busy;
  logic [DATASIZE-1:0]      wdata;
  logic [IDW-1:0]           grant_id;
  logic [31:0]              beat_cnt_total;

  fifo_wr_arbiter #(.DATASIZE(DATASIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .w_en(w_en), .wdata(wdata),
    .grant_id(grant_id), .busy(busy), .beat_cnt_total(beat_cnt_total)
  );

  // 100 MHz write clock, 33 MHz read clock with edges never coinciding
  initial begin wclk = 0; forever #5 wclk = ~wclk; end
  initial begin rclk = 0; #2; forever #15 rclk = ~rclk; end

  int n_checks = 0;
  int n_err    = 0;

  // stimulus state
  int              words_left[NREQ];
  bit              have_word[NREQ];
  logic [63:0]     cur_word[NREQ];
  int              seq[NREQ];
  logic [NREQ-1:0] en = '0;
  bit              rand_mode = 0;
  int              rand_pct = 100;
  bit              force_full = 0;
  bit              rd_en = 1;
  bit              full_seen = 0;

  // scoreboard and FIFO model
  logic [63:0]     exp_q[NREQ][$];
  logic [63:0]     fifo_q[$];
  int              fifo_wr_count = 0;
  logic [NREQ-1:0] acc = '0;
  bit              wr_pend = 0;
  logic [63:0]     wr_word;

  // reference arbitration model
  bit              exp_busy = 0;
  logic [IDW-1:0]  exp_gid = '0;
  int              last_id = NREQ - 1;
  int              total_writes = 0;
  int              cur_beats = 0;
  bit              in_burst = 0;
  int              gid_log[$];
  int              len_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First valid requester after 'last', wrapping around
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  // Driver: FIFO write on the edge, new inputs 1 ns later
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      words_left[i] = 0; have_word[i] = 0; seq[i] = 0; cur_word[i] = '0;
    end
    forever begin
      @(posedge wclk);
      if (wr_pend) begin
        fifo_q.push_back(wr_word);
        fifo_wr_count++;
      end
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          have_word[i] = 0;
          words_left[i]--;
        end
        if (!have_word[i] && words_left[i] > 0) begin
          cur_word[i] = {8'(i), 24'(seq[i]), 32'($urandom)};
          seq[i]++;
          exp_q[i].push_back(cur_word[i]);
          have_word[i] = 1;
        end
        req_data[i*DATASIZE +: DATASIZE] = cur_word[i];
        req_valid[i] = en[i] && have_word[i] &&
                       (!rand_mode || ($urandom_range(0, 99) < rand_pct));
      end
      acc     = '0;
      wr_pend = 0;
      wfull   = force_full || (fifo_q.size() >= DEPTH);
      if (wfull && rand_mode) full_seen = 1;
    end
  end

  // FIFO read side
  initial begin
    forever begin
      @(posedge rclk);
      if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
  end

  // Monitor: mid-cycle sample of what the next rising edge will act on
  initial begin
    forever begin
      @(negedge wclk);
      if (!wrst_n) begin
        exp_busy = 0; last_id = NREQ - 1; total_writes = 0;
        cur_beats = 0; in_burst = 0; acc = '0; wr_pend = 0;
      end else begin
        chk("busy", busy, exp_busy);
        if (busy && exp_busy) chk("grant_id", grant_id, exp_gid);
        chk("beat_cnt_total", beat_cnt_total, total_writes);
        if (!busy) begin
          chk("idle_wen_ready", {req_ready, w_en}, '0);
          chk("idle_wdata", wdata, '0);
        end else begin
          chk("w_en_rule", w_en, req_valid[grant_id] && !wfull);
          chk("req_ready", req_ready, w_en ? (NREQ'(1) << grant_id) : NREQ'(0));
        end
        if (busy && !in_burst) begin
          in_burst  = 1;
          cur_beats = 0;
        end
        if (w_en) begin
          chk("write_while_full", fifo_q.size() >= DEPTH, 0);
          if (exp_q[grant_id].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL wdata_order: requester %0d wrote 0x%0h, expected no word", grant_id, wdata);
          end else begin
            chk("wdata_order", wdata, exp_q[grant_id].pop_front());
          end
          cur_beats++;
          total_writes++;
          acc     = req_ready;
          wr_pend = 1;
          wr_word = wdata;
        end
        if (busy) begin
          if (!req_valid[grant_id] || (w_en && cur_beats == BURST)) begin
            exp_busy = 0;
            last_id  = int'(grant_id);
            gid_log.push_back(int'(grant_id));
            len_log.push_back(cur_beats);
            in_burst = 0;
          end else begin
            exp_busy = 1;
            exp_gid  = grant_id;
          end
        end else begin
          exp_busy = (req_valid != '0);
          if (exp_busy) exp_gid = IDW'(rr_pick(last_id, req_valid));
        end
      end
    end
  end

  task automatic bench_reset();
    wrst_n     = 0;
    en         = '0;
    rand_mode  = 0;
    force_full = 0;
    rd_en      = 1;
    full_seen  = 0;
    for (int i = 0; i < NREQ; i++) begin
      words_left[i] = 0;
      have_word[i]  = 0;
      exp_q[i].delete();
    end
    fifo_q.delete();
    fifo_wr_count = 0;
    acc = '0;
    wr_pend = 0;
    gid_log.delete();
    len_log.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge wclk);
    #2 wrst_n = 1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit done = 0;
    int sum;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge wclk);
      #2;
      sum = 0;
      for (int i = 0; i < NREQ; i++) sum += words_left[i];
      if (sum == 0 && !busy) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_%s: words still pending after %0d cycles", name, budget);
    end
    repeat (3) @(posedge wclk);
    #2;
  endtask

  task automatic wait_beats(input int n, input string name);
    bit hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge wclk);
      if (in_burst && cur_beats == n) hit = 1;
    end
    if (!hit) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_%s: beat %0d never reached", name, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    wfull     = 0;
    wrst_n    = 1;
    #1;
    bench_reset();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_total", beat_cnt_total, 0);
    release_reset();

    // Single requester, 20 words: bursts 8, 8, 4
    en = 4'b0001;
    words_left[0] = 20;
    wait_done(500, "single");
    chk("single_nbursts", len_log.size(), 3);
    for (int k = 0; k < len_log.size() && k < 3; k++) begin
      chk("single_len", len_log[k], (k < 2) ? 8 : 4);
      chk("single_gid", gid_log[k], 0);
    end
    chk("single_total", beat_cnt_total, 20);
    chk("single_fifo_writes", fifo_wr_count, 20);

    // Four requesters continuously valid: 0,1,2,3,0,... each 8 beats
    @(posedge wclk); #2; bench_reset(); release_reset();
    en = 4'b1111;
    for (int i = 0; i < NREQ; i++) words_left[i] = 16;
    wait_done(1000, "four");
    chk("four_nbursts", len_log.size(), 8);
    for (int k = 0; k < len_log.size() && k < 8; k++) begin
      chk("four_gid", gid_log[k], k % NREQ);
      chk("four_len", len_log[k], 8);
    end
    chk("four_total", beat_cnt_total, 64);

    // Backpressure during beat 3: five stalled cycles, burst still 8 beats
    @(posedge wclk); #2; bench_reset(); release_reset();
    en = 4'b0001;
    words_left[0] = 8;
    wait_beats(3, "bp");
    force_full = 1;
    repeat (5) begin
      @(negedge wclk);
      chk("bp_w_en", w_en, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_total_held", beat_cnt_total, 3);
    end
    @(posedge wclk);
    force_full = 0;
    wait_done(200, "bp");
    chk("bp_nbursts", len_log.size(), 1);
    if (len_log.size() > 0) chk("bp_len", len_log[0], 8);
    chk("bp_total", beat_cnt_total, 8);

    // Early release: requester 2 stops after 3 beats, requester 3 follows
    @(posedge wclk); #2; bench_reset(); release_reset();
    en = 4'b1100;
    words_left[2] = 3;
    words_left[3] = 8;
    wait_done(300, "early");
    chk("early_nbursts", len_log.size(), 2);
    if (len_log.size() >= 2) begin
      chk("early_gid0", gid_log[0], 2);
      chk("early_len0", len_log[0], 3);
      chk("early_gid1", gid_log[1], 3);
      chk("early_len1", len_log[1], 8);
    end

    // Reset mid-burst at beat 5, then first grant from index 0 upward
    @(posedge wclk); #2; bench_reset(); release_reset();
    en = 4'b0001;
    words_left[0] = 20;
    wait_beats(5, "rstmid");
    #2;
    chk("rstmid_pre_wen", w_en, 1);
    wrst_n = 0;
    #1;
    chk("rstmid_w_en", w_en, 0);
    chk("rstmid_ready", req_ready, 0);
    chk("rstmid_wdata", wdata, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_gid", grant_id, 0);
    chk("rstmid_total", beat_cnt_total, 0);
    bench_reset();
    en = 4'b1010;
    words_left[1] = 4;
    words_left[3] = 4;
    release_reset();
    wait_done(300, "rstmid");
    chk("rstmid_nbursts", len_log.size(), 2);
    if (len_log.size() >= 2) begin
      chk("rstmid_first_gid", gid_log[0], 1);
      chk("rstmid_second_gid", gid_log[1], 3);
    end
    chk("rstmid_after_total", beat_cnt_total, 8);

    // Random valid patterns against the 128-deep FIFO model
    @(posedge wclk); #2; bench_reset(); release_reset();
    en        = 4'b1111;
    rand_mode = 1;
    rand_pct  = 75;
    rd_en     = 0;
    for (int i = 0; i < NREQ; i++) words_left[i] = 120;
    repeat (250) @(posedge wclk);
    rd_en = 1;
    wait_done(20000, "random");
    chk("rand_full_seen", full_seen, 1);
    for (int i = 0; i < NREQ; i++) chk("rand_pending_words", exp_q[i].size(), 0);
    chk("rand_total_vs_fifo", beat_cnt_total, fifo_wr_count);
    chk("rand_total", beat_cnt_total, 480);
    for (int k = 0; k < len_log.size(); k++) begin
      if (len_log[k] > BURST) chk("rand_burst_len", len_log[k], BURST);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 64: FIFO word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4: number of write requesters; ID width IDW = clog2(NREQ), minimum 1.
REQ-003 The block SHALL have parameter BURST, default 8: maximum beats per grant; legal range 1..255.
REQ-004 The block SHALL have these ports:
- wclk  in  1  write-domain clock; single clock, all state on rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DATASIZE  per-requester data; requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_ready  out  NREQ  per-requester beat accepted this cycle.
- wfull  in  1  FIFO full flag, synchronous to wclk.
- w_en  out  1  FIFO write enable.
- wdata  out  DATASIZE  FIFO write data.
- grant_id  out  IDW  currently granted requester.
- busy  out  1  high while in GRANT.
- beat_cnt_total  out  32  total beats written to FIFO; wraps.

Function
REQ-005 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-006 In IDLE with any req_valid bit high, the block SHALL select the first valid requester searching round-robin from (last_gnt+1) mod NREQ upward, load grant_id, clear the burst counter, and enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-007 In IDLE, w_en and all req_ready bits SHALL be 0.
REQ-008 In GRANT, w_en SHALL be combinational: req_valid[grant_id] AND NOT wfull.
REQ-009 In GRANT, req_ready[grant_id] SHALL equal w_en and all other req_ready bits SHALL be 0; this gives zero-latency pass-through.
REQ-010 wdata SHALL be the combinational mux req_data[grant_id] whenever in GRANT, and all-zero in IDLE.
REQ-011 Each cycle with w_en=1 is one beat: the 8-bit burst counter SHALL increment and beat_cnt_total SHALL increment mod 2^32.
REQ-012 GRANT SHALL return to IDLE and set last_gnt = grant_id when a beat is taken with the burst counter equal to BURST-1.
REQ-013 GRANT SHALL also return to IDLE and set last_gnt = grant_id when req_valid[grant_id] is 0 in any cycle, even mid-burst; no beat is written in that cycle.
REQ-014 While wfull=1 in GRANT, the block SHALL stall: no beat, counter held, state held, grant not released, ready low.
REQ-015 When wfull and a drop of req_valid[grant_id] coincide, the block SHALL follow REQ-013 (release).
REQ-016 Every grant SHALL pass through IDLE, so a requester that stays valid loses at least 1 cycle between consecutive bursts.
REQ-017 A requester SHALL never be granted twice while another requester was valid during the intervening IDLE cycle, which is the round-robin fairness rule.
REQ-018 The block SHALL never assert w_en while wfull=1, so FIFO overflow is impossible.
REQ-019 busy SHALL be 1 exactly in GRANT.

Reset
REQ-020 Asserting wrst_n low SHALL immediately force: state IDLE, grant_id 0, last_gnt NREQ-1, burst counter 0, beat_cnt_total 0, busy 0, w_en 0, req_ready 0, wdata 0.
REQ-021 Reset asserted mid-burst SHALL abort the burst without a partial write in the reset cycle.
REQ-022 After wrst_n deasserts, the first grant SHALL go to the lowest-index valid requester starting from 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single requester: req_valid=0001, wfull=0, 20 words -> grants of 8, 8, 4 beats with a 1-cycle IDLE gap before each; FIFO receives words in order; beat_cnt_total=20.
- Four requesters all valid continuously -> grant_id sequence 0,1,2,3,0,...; each grant is 8 beats; never two back-to-back grants to the same ID.
- Backpressure: wfull=1 for 5 cycles during beat 3 of a burst -> w_en=0 and req_ready=0 for those cycles, counter held at 3, burst completes with exactly 8 beats.
- Early release: requester 2 drops valid after 3 beats while requester 3 is valid -> IDLE for 1 cycle, then grant_id=3.
- Reset mid-burst: wrst_n low at beat 5 -> all outputs 0 in the same cycle; after release with req_valid=1010, first grant_id=1.
- Overflow check: random valid patterns against a 128-deep FIFO model (ADDRSIZE 7), 64-bit data, write clock 100 MHz and read clock 33 MHz -> no write while full; per-requester data order preserved; beat_cnt_total equals the FIFO write count.
